// File: rtl/pipe_reg_slice_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared types and constants for the pipe_reg_slice family.
//                Slice mode selector and occupancy counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Elaboration-time selection of the register slice flavour
    typedef enum logic [1:0] {
        SLICE_BYPASS = 2'd0,
        SLICE_FWD    = 2'd1,
        SLICE_REV    = 2'd2,
        SLICE_FULL   = 2'd3
    } slice_mode_e;

    // Width of the occupancy counter (holds 0..2)
    localparam int unsigned CNT_W = 2;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_reg_slice_store2.sv
`default_nettype none
// ============================================================================
//  Module      : slice_store2
//  Description : Two-entry circular buffer with 1-bit head/tail pointers and
//                an occupancy count. Full/empty decode straight from flops so
//                the enclosing slice has no input-to-output combinational path.
//  Revision    : 1.0 - initial release
// ============================================================================
module slice_store2
    import pipe_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [DW-1:0]    data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [DW-1:0]    data_o,
    output logic [CNT_W-1:0] count_o
);

    logic [DW-1:0]    mem_q [2];
    logic             head_q;
    logic             head_d;
    logic             tail_q;
    logic             tail_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             w_push;
    logic             w_pop;

    // Push/pop are qualified here as well so a misbehaving caller can never
    // overflow or underflow the counter.
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;

    assign full_o  = (count_q == CNT_W'(2));
    assign empty_o = (count_q == CNT_W'(0));
    assign data_o  = mem_q[head_q];
    assign count_o = count_q;

    // Pointer and occupancy next-state; clear wins over any handshake
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear_i) begin
            head_d  = 1'b0;
            tail_d  = 1'b0;
            count_d = '0;
        end else begin
            if (w_push) begin
                tail_d = ~tail_q;
            end
            if (w_pop) begin
                head_d = ~head_q;
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; a beat pushed during a clear cycle is discarded
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else if (w_push && !clear_i) begin
            mem_q[tail_q] <= data_i;
        end
    end

endmodule : slice_store2
`default_nettype wire

// File: rtl/pipe_reg_slice.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_reg_slice
//  Description : Valid/ready register slice with elaboration-time mode:
//                bypass, forward-registered, reverse-registered (skid) or
//                fully registered (2-entry). Reports occupancy on count_o.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_reg_slice
    import pipe_pkg::*;
#(
    parameter int unsigned DW   = 8,
    parameter slice_mode_e MODE = SLICE_FULL
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [DW-1:0]    data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [DW-1:0]    data_o,
    output logic [CNT_W-1:0] count_o
);

    generate
        case (MODE)

            SLICE_BYPASS: begin : g_bypass
                // Pure wires; clock/reset/clear have no effect in this mode.
                logic w_unused_bypass;
                assign w_unused_bypass = clk_i ^ rst_i ^ clear_i;

                assign valid_o = valid_i;
                assign data_o  = data_i;
                assign ready_o = ready_i;
                assign count_o = '0;
            end

            SLICE_FWD: begin : g_fwd
                logic          valid_q;
                logic          valid_d;
                logic [DW-1:0] data_q;
                logic [DW-1:0] data_d;
                logic          w_accept;
                logic          w_xfer;

                // Register may refill in the same cycle it drains downstream
                assign ready_o  = ready_i || !valid_q;
                assign w_accept = valid_i && ready_o;
                assign w_xfer   = valid_q && ready_i;

                assign valid_o  = valid_q;
                assign data_o   = data_q;
                assign count_o  = {1'b0, valid_q};

                // Output register next-state: load on accept, empty on drain
                always_comb begin
                    valid_d = valid_q;
                    data_d  = data_q;
                    if (clear_i) begin
                        valid_d = 1'b0;
                    end else if (w_accept) begin
                        valid_d = 1'b1;
                        data_d  = data_i;
                    end else if (w_xfer) begin
                        valid_d = 1'b0;
                    end
                end

                // Output register
                always_ff @(posedge clk_i or posedge rst_i) begin
                    if (rst_i) begin
                        valid_q <= 1'b0;
                        data_q  <= '0;
                    end else begin
                        valid_q <= valid_d;
                        data_q  <= data_d;
                    end
                end
            end

            SLICE_REV: begin : g_rev
                logic          ready_q;
                logic          ready_d;
                logic [DW-1:0] skid_q;
                logic [DW-1:0] skid_d;

                // While ready is high the slice is transparent; once a beat is
                // parked in the skid entry it is presented until drained.
                assign ready_o = ready_q;
                assign valid_o = ready_q ? valid_i : 1'b1;
                assign data_o  = ready_q ? data_i  : skid_q;
                assign count_o = {1'b0, !ready_q};

                // Skid capture when downstream stalls, release when it drains
                always_comb begin
                    ready_d = ready_q;
                    skid_d  = skid_q;
                    if (clear_i) begin
                        ready_d = 1'b1;
                    end else if (ready_q) begin
                        if (valid_i && !ready_i) begin
                            skid_d  = data_i;
                            ready_d = 1'b0;
                        end
                    end else if (ready_i) begin
                        ready_d = 1'b1;
                    end
                end

                // Registered ready and skid entry
                always_ff @(posedge clk_i or posedge rst_i) begin
                    if (rst_i) begin
                        ready_q <= 1'b1;
                        skid_q  <= '0;
                    end else begin
                        ready_q <= ready_d;
                        skid_q  <= skid_d;
                    end
                end
            end

            SLICE_FULL: begin : g_full
                logic w_full;
                logic w_empty;

                // Both handshake outputs decode from storage flops only
                assign ready_o = !w_full;
                assign valid_o = !w_empty;

                slice_store2 #(
                    .DW (DW)
                ) u_store (
                    .clk_i   (clk_i),
                    .rst_i   (rst_i),
                    .clear_i (clear_i),
                    .push_i  (valid_i && !w_full),
                    .pop_i   (ready_i && !w_empty),
                    .data_i  (data_i),
                    .full_o  (w_full),
                    .empty_o (w_empty),
                    .data_o  (data_o),
                    .count_o (count_o)
                );
            end

            default: begin : g_invalid
                logic w_unused_invalid;
                assign w_unused_invalid = clk_i ^ rst_i ^ clear_i ^ valid_i ^ ready_i ^ (^data_i);

                assign valid_o = 1'b0;
                assign data_o  = '0;
                assign ready_o = 1'b0;
                assign count_o = '0;
            end

        endcase
    endgenerate

endmodule : pipe_reg_slice
`default_nettype wire

// File: tb/tb_pipe_reg_slice.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_reg_slice
//  Description : Directed self-checking bench for pipe_reg_slice. One
//                instance per mode (0 BYPASS, 1 FWD, 2 REV, 3 FULL) on a
//                shared clock/reset/clear, each with its own stream ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_reg_slice;
    import pipe_pkg::*;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       vi   [4];
    logic       ri   [4];
    logic [7:0] di   [4];
    logic       vo   [4];
    logic       ro   [4];
    logic [7:0] dout [4];
    logic [1:0] cnt  [4];

    int n_total;
    int n_bad;

    pipe_reg_slice #(.DW(8), .MODE(SLICE_BYPASS)) u_byp (
        .clk_i(clk), .rst_i(rst), .clear_i(clr),
        .valid_i(vi[0]), .ready_o(ro[0]), .data_i(di[0]),
        .valid_o(vo[0]), .ready_i(ri[0]), .data_o(dout[0]), .count_o(cnt[0]));

    pipe_reg_slice #(.DW(8), .MODE(SLICE_FWD)) u_fwd (
        .clk_i(clk), .rst_i(rst), .clear_i(clr),
        .valid_i(vi[1]), .ready_o(ro[1]), .data_i(di[1]),
        .valid_o(vo[1]), .ready_i(ri[1]), .data_o(dout[1]), .count_o(cnt[1]));

    pipe_reg_slice #(.DW(8), .MODE(SLICE_REV)) u_rev (
        .clk_i(clk), .rst_i(rst), .clear_i(clr),
        .valid_i(vi[2]), .ready_o(ro[2]), .data_i(di[2]),
        .valid_o(vo[2]), .ready_i(ri[2]), .data_o(dout[2]), .count_o(cnt[2]));

    pipe_reg_slice #(.DW(8), .MODE(SLICE_FULL)) u_full (
        .clk_i(clk), .rst_i(rst), .clear_i(clr),
        .valid_i(vi[3]), .ready_o(ro[3]), .data_i(di[3]),
        .valid_o(vo[3]), .ready_i(ri[3]), .data_o(dout[3]), .count_o(cnt[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Advance one active edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // FWD scenario tables: ready_i and data_i per edge, expected state after
    logic       fwd_ri   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] fwd_di   [5] = '{8'h10, 8'h11, 8'h11, 8'h12, 8'h12};
    logic [7:0] fwd_dexp [5] = '{8'h10, 8'h10, 8'h11, 8'h11, 8'h12};

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst     = 1'b1;
        clr     = 1'b0;
        for (int k = 0; k < 4; k++) begin
            vi[k] = 1'b0;
            ri[k] = 1'b0;
            di[k] = 8'h00;
        end

        // ---------------- reset state ----------------
        #2;
        check_val("rst_full_ready", ro[3], 1);
        check_val("rst_full_valid", vo[3], 0);
        check_val("rst_full_count", cnt[3], 0);
        check_val("rst_full_data",  dout[3], 0);
        check_val("rst_fwd_ready",  ro[1], 1);
        check_val("rst_fwd_valid",  vo[1], 0);
        check_val("rst_rev_ready",  ro[2], 1);
        check_val("rst_rev_valid",  vo[2], 0);
        di[0] = 8'h3C;
        vi[0] = 1'b1;
        ri[0] = 1'b1;
        #1;
        check_val("byp_ready", ro[0], 1);
        check_val("byp_valid", vo[0], 1);
        check_val("byp_data",  dout[0], 8'h3C);
        check_val("byp_count", cnt[0], 0);
        #7;
        rst = 1'b0;

        // ---------------- FULL streaming ----------------
        ri[3] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            vi[3] = 1'b1;
            di[3] = 8'(i);
            tick();
            check_val("full_stream_valid", vo[3], 1);
            check_val("full_stream_data",  dout[3], i);
            check_val("full_stream_count", cnt[3], 1);
        end
        vi[3] = 1'b0;
        tick();
        check_val("full_stream_drain_count", cnt[3], 0);
        check_val("full_stream_drain_valid", vo[3], 0);

        // ---------------- FULL back-pressure ----------------
        ri[3] = 1'b0;
        vi[3] = 1'b1;
        di[3] = 8'hA1;
        tick();
        check_val("full_bp_cnt1",   cnt[3], 1);
        check_val("full_bp_ready1", ro[3], 1);
        di[3] = 8'hA2;
        tick();
        check_val("full_bp_cnt2",   cnt[3], 2);
        check_val("full_bp_ready2", ro[3], 0);
        di[3] = 8'hA3;
        tick();
        check_val("full_bp_hold_cnt",  cnt[3], 2);
        check_val("full_bp_hold_data", dout[3], 8'hA1);
        ri[3] = 1'b1;
        tick();
        check_val("full_bp_out_a2",  dout[3], 8'hA2);
        check_val("full_bp_cnt_a2",  cnt[3], 1);
        check_val("full_bp_ready_a2", ro[3], 1);
        tick();
        vi[3] = 1'b0;
        check_val("full_bp_out_a3", dout[3], 8'hA3);
        check_val("full_bp_cnt_a3", cnt[3], 1);
        tick();
        check_val("full_bp_empty", cnt[3], 0);
        check_val("full_bp_valid", vo[3], 0);

        // ---------------- REV skid ----------------
        vi[2] = 1'b1;
        di[2] = 8'h55;
        ri[2] = 1'b0;
        #1;
        check_val("rev_pass_valid", vo[2], 1);
        check_val("rev_pass_data",  dout[2], 8'h55);
        check_val("rev_pass_ready", ro[2], 1);
        tick();
        vi[2] = 1'b0;
        di[2] = 8'h66;
        #1;
        check_val("rev_skid_ready", ro[2], 0);
        check_val("rev_skid_valid", vo[2], 1);
        check_val("rev_skid_data",  dout[2], 8'h55);
        check_val("rev_skid_count", cnt[2], 1);
        ri[2] = 1'b1;
        tick();
        check_val("rev_drain_ready", ro[2], 1);
        check_val("rev_drain_valid", vo[2], 0);
        check_val("rev_drain_count", cnt[2], 0);

        // ---------------- FWD toggling ready ----------------
        vi[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ri[1] = fwd_ri[i];
            di[1] = fwd_di[i];
            #1;
            check_val("fwd_ready_pre", ro[1], (i == 0) ? 1 : 32'(fwd_ri[i]));
            tick();
            check_val("fwd_valid", vo[1], 1);
            check_val("fwd_data",  dout[1], fwd_dexp[i]);
            check_val("fwd_count", cnt[1], 1);
        end
        vi[1] = 1'b0;
        ri[1] = 1'b1;
        tick();
        check_val("fwd_drain_valid", vo[1], 0);
        check_val("fwd_drain_count", cnt[1], 0);

        // ---------------- FULL clear ----------------
        ri[3] = 1'b0;
        vi[3] = 1'b1;
        di[3] = 8'hB1;
        tick();
        di[3] = 8'hB2;
        tick();
        check_val("clr_pre_count", cnt[3], 2);
        di[3] = 8'hB3;
        clr   = 1'b1;
        tick();
        clr   = 1'b0;
        vi[3] = 1'b0;
        check_val("clr_count", cnt[3], 0);
        check_val("clr_valid", vo[3], 0);
        check_val("clr_ready", ro[3], 1);
        ri[3] = 1'b1;
        tick();
        check_val("clr_no_ghost", vo[3], 0);
        vi[3] = 1'b1;
        di[3] = 8'hC1;
        tick();
        check_val("clr_after_data", dout[3], 8'hC1);
        check_val("clr_after_cnt",  cnt[3], 1);

        // ---------------- async reset mid-stream ----------------
        ri[3] = 1'b0;
        di[3] = 8'hD1;
        vi[1] = 1'b1;
        ri[1] = 1'b0;
        di[1] = 8'hD1;
        tick();
        vi[3] = 1'b0;
        vi[1] = 1'b0;
        check_val("arst_pre_full_cnt", cnt[3], 2);
        check_val("arst_pre_fwd_data", dout[1], 8'hD1);
        #3;
        rst = 1'b1;
        #1;
        check_val("arst_full_cnt",   cnt[3], 0);
        check_val("arst_full_valid", vo[3], 0);
        check_val("arst_full_ready", ro[3], 1);
        check_val("arst_full_data",  dout[3], 0);
        check_val("arst_fwd_valid",  vo[1], 0);
        check_val("arst_fwd_data",   dout[1], 0);
        #1;
        rst = 1'b0;
        vi[3] = 1'b1;
        ri[3] = 1'b1;
        di[3] = 8'hE1;
        tick();
        check_val("arst_post_data", dout[3], 8'hE1);
        check_val("arst_post_cnt",  cnt[3], 1);
        vi[3] = 1'b0;
        tick();
        check_val("arst_post_empty", cnt[3], 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_pipe_reg_slice
`default_nettype wire
